// File: rtl/pe_array_pkg.sv
// Shared types and sizing for the PE result-RAM reader.
// Array geometry lives here so the reader and its output FIFO agree on the word layout.
package pe_array_pkg;
    localparam int D_WIDTH      = 64;
    localparam int A_PART_WIDTH = 1;
    localparam int B_NUM_WIDTH  = 1;
    localparam int PE_NUM       = 4;
    localparam int PE_SEL_WIDTH = 2;
    localparam int ADDR_WIDTH   = A_PART_WIDTH + B_NUM_WIDTH;

    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT
    } rd_state_e;

    typedef struct packed {
        logic [D_WIDTH-1:0]      data;
        logic [PE_SEL_WIDTH-1:0] pid;
        logic                    last;
    } res_word_t;
endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO of result words with occupancy count; head is zero when empty.
// The caller only pushes when its credit check guarantees room.
module rd_skid_fifo
    import pe_array_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  res_word_t  din,
    input  logic       pop,
    output res_word_t  dout,
    output logic       valid,
    output logic [1:0] count
);
    res_word_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign valid = (count != 2'd0);
    assign dout  = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/pe_result_reader.sv
// Drains finished PE result RAMs one PE at a time into a valid/ready stream.
// Optional PE_RD_STATS_EN adds transfer and stall counters.
//   state | meaning
//   IDLE  | no PE selected; picks lowest pending PE
//   READ  | issuing reads for sel, address 0..DEPTH-1, gated by FIFO credit
//   WAIT  | all reads issued; waiting for the last word to land in the FIFO
module pe_result_reader
    import pe_array_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PE_NUM-1:0]                 trigger_in,
    output logic [PE_NUM-1:0]                 res_rd_en_out,
    output logic [ADDR_WIDTH-1:0]             res_rd_addr_out,
    input  logic [PE_NUM-1:0][D_WIDTH-1:0]    res_rd_data_in,
    output logic [D_WIDTH-1:0]                m_data_out,
    output logic [PE_SEL_WIDTH-1:0]           m_pid_out,
    output logic                              m_last_out,
    output logic                              m_valid_out,
    input  logic                              m_ready_in,
    output logic                              busy_out,
    output logic                              err_retrig_out
`ifdef PE_RD_STATS_EN
    ,
    output logic [31:0]                       stat_words_out,
    output logic [31:0]                       stat_stall_out
`endif
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    rd_state_e               state;
    logic [PE_NUM-1:0]       trig_q;
    logic [PE_NUM-1:0]       pending;
    logic [PE_NUM-1:0]       trig_edge;
    logic [PE_NUM-1:0]       sel_mask;
    logic [PE_NUM-1:0]       first_mask;
    logic [PE_NUM-1:0]       clr_mask;
    logic [PE_NUM-1:0]       block_mask;
    logic [PE_SEL_WIDTH-1:0] sel;
    logic [PE_SEL_WIDTH-1:0] first_pid;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    inflight;
    logic                    inflight_last;
    logic [1:0]              fifo_cnt;
    logic                    pop;
    logic                    issue;
    logic                    credit_ok;
    res_word_t               cap;
    res_word_t               head;

    assign trig_edge  = trigger_in & ~trig_q;
    assign sel_mask   = {{(PE_NUM-1){1'b0}}, 1'b1} << sel;
    assign first_mask = {{(PE_NUM-1){1'b0}}, 1'b1} << first_pid;

    always_comb begin
        first_pid = '0;
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            if (pending[i]) begin
                first_pid = PE_SEL_WIDTH'(i);
            end
        end
    end

    // A read issued now lands in the FIFO next cycle, so count it against the two slots.
    assign pop       = m_valid_out & m_ready_in;
    assign credit_ok = ({1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    assign issue     = (state == READ) && credit_ok;

    assign res_rd_en_out   = issue ? sel_mask : '0;
    assign res_rd_addr_out = addr;

    assign clr_mask   = ((state == IDLE) && (pending != '0)) ? first_mask : '0;
    assign block_mask = (state != IDLE) ? sel_mask : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            trig_q         <= '0;
            pending        <= '0;
            sel            <= '0;
            addr           <= '0;
            inflight       <= 1'b0;
            inflight_last  <= 1'b0;
            err_retrig_out <= 1'b0;
        end else begin
            trig_q         <= trigger_in;
            inflight       <= issue;
            inflight_last  <= issue && (addr == LAST_ADDR);
            pending        <= (pending & ~clr_mask) | (trig_edge & ~block_mask);
            err_retrig_out <= err_retrig_out | (|(trig_edge & block_mask));
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        sel   <= first_pid;
                        addr  <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        addr <= addr + 1'b1;
                        if (addr == LAST_ADDR) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (inflight && inflight_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cap = '{data: res_rd_data_in[sel], pid: sel, last: inflight_last};

    rd_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (cap),
        .pop   (pop),
        .dout  (head),
        .valid (m_valid_out),
        .count (fifo_cnt)
    );

    assign m_data_out = head.data;
    assign m_pid_out  = head.pid;
    assign m_last_out = head.last;
    assign busy_out   = (state != IDLE) || (fifo_cnt != 2'd0);

`ifdef PE_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words_out <= '0;
            stat_stall_out <= '0;
        end else begin
            stat_words_out <= stat_words_out + 32'(pop);
            stat_stall_out <= stat_stall_out + 32'(m_valid_out & ~m_ready_in);
        end
    end
`endif
endmodule
